// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared definitions for the boot-time RAM loader.
//   - default widths/depth of the RAM the loader feeds
//   - 3-bit FSM state encodings and the state enum built from them
//   - frame length range helper
package ram_loader_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH_DEF  = 16;
  localparam int MAX_LEN    = DEPTH_DEF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEN   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CSUM  = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_LEN   = ST_LEN,
    S_DATA  = ST_DATA,
    S_CSUM  = ST_CSUM,
    S_RUN   = ST_RUN,
    S_ERROR = ST_ERROR
  } state_t;

  // A frame length is usable only if it is non-zero and fits in the RAM.
  function automatic logic len_valid(input logic [31:0] n, input logic [31:0] max_len);
    return (n != 32'd0) && (n <= max_len);
  endfunction

endpackage

// File: rtl/ram_loader_acc.sv
// ram_loader_acc: running payload checksum plus write address and byte count.
//   clk, reset : clock and synchronous active-high reset (all state to 0)
//   clr        : start a new frame (sum=0, addr=BASE_ADDR, count=0); wins over en
//   en         : one payload byte accepted: sum += data, addr += 1 (wraps), count += 1
//   data       : payload byte
//   sum        : checksum of the payload so far, mod 2**DATA_W
//   addr       : RAM address for the next payload byte
//   count      : payload bytes taken since the last clr
module ram_loader_acc
  import ram_loader_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] sum,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   count
);

  logic [DATA_W-1:0] sum_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   count_r;

  // Accumulator state; the address register is exactly ADDR_W wide so it wraps mod DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r   <= '0;
      addr_r  <= '0;
      count_r <= '0;
    end else if (clr) begin
      sum_r   <= '0;
      addr_r  <= ADDR_W'(BASE_ADDR);
      count_r <= '0;
    end else if (en) begin
      sum_r   <= sum_r + data;
      addr_r  <= addr_r + ADDR_W'(1);
      count_r <= count_r + (ADDR_W+1)'(1);
    end else begin
      sum_r   <= sum_r;
      addr_r  <= addr_r;
      count_r <= count_r;
    end
  end

  assign sum   = sum_r;
  assign addr  = addr_r;
  assign count = count_r;

endmodule

// File: rtl/ram_loader.sv
// ram_loader: boot loader that writes a framed byte stream into RAM and then
// releases the CPU. Frame = LEN (1..DEPTH), LEN payload bytes, CSUM (sum mod 2**DATA_W).
//   clk, reset   : clock, synchronous active-high reset
//   start        : begin a (re)load; honoured in IDLE, RUN and ERROR only
//   in_valid     : upstream byte valid
//   in_data      : upstream byte
//   in_ready     : loader accepts a byte this cycle (LEN, DATA, CSUM)
//   mem_we       : RAM write strobe, one cycle after each payload accept
//   mem_addr     : RAM write address (holds between writes)
//   mem_wdata    : RAM write data (holds between writes)
//   cpu_run      : core may run (only after a clean load)
//   done         : last load succeeded
//   err          : last load failed (bad length or checksum)
//   words_loaded : payload bytes written in the current/last load
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  state_t            state_r, state_nxt;
  logic [ADDR_W:0]   rem_r, rem_nxt;
  logic              accept_s;
  logic              acc_clr_s;
  logic              acc_en_s;
  logic [DATA_W-1:0] acc_sum_s;
  logic [ADDR_W-1:0] acc_addr_s;

  logic              in_ready_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              cpu_run_r;
  logic              done_r;
  logic              err_r;

  assign accept_s = in_valid & in_ready_r;

  ram_loader_acc #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (acc_clr_s),
    .en    (acc_en_s),
    .data  (in_data),
    .sum   (acc_sum_s),
    .addr  (acc_addr_s),
    .count (words_loaded)
  );

  // State and remaining-byte counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      rem_r   <= '0;
    end else begin
      state_r <= state_nxt;
      rem_r   <= rem_nxt;
    end
  end

  // Next-state logic and accumulator control.
  always_comb begin
    state_nxt = state_r;
    rem_nxt   = rem_r;
    acc_clr_s = 1'b0;
    acc_en_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt = S_LEN;
        else       state_nxt = S_IDLE;
      end
      S_LEN: begin
        if (accept_s) begin
          if (len_valid(32'(in_data), 32'(DEPTH))) begin
            acc_clr_s = 1'b1;
            rem_nxt   = in_data[ADDR_W:0];
            state_nxt = S_DATA;
          end else begin
            state_nxt = S_ERROR;
          end
        end else begin
          state_nxt = S_LEN;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          acc_en_s = 1'b1;
          rem_nxt  = rem_r - (ADDR_W+1)'(1);
          if (rem_r == (ADDR_W+1)'(1)) state_nxt = S_CSUM;
          else                         state_nxt = S_DATA;
        end else begin
          state_nxt = S_DATA;
        end
      end
      S_CSUM: begin
        // The accumulator already includes the last payload byte here.
        if (accept_s) begin
          if (in_data == acc_sum_s) state_nxt = S_RUN;
          else                      state_nxt = S_ERROR;
        end else begin
          state_nxt = S_CSUM;
        end
      end
      S_RUN, S_ERROR: begin
        if (start) state_nxt = S_LEN;
        else       state_nxt = state_r;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs: status decoded from the next state, write port from the accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      cpu_run_r   <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      in_ready_r <= (state_nxt == S_LEN) || (state_nxt == S_DATA) || (state_nxt == S_CSUM);
      cpu_run_r  <= (state_nxt == S_RUN);
      done_r     <= (state_nxt == S_RUN);
      err_r      <= (state_nxt == S_ERROR);
      mem_we_r   <= acc_en_s;
      if (acc_en_s) begin
        mem_addr_r  <= acc_addr_s;
        mem_wdata_r <= in_data;
      end else begin
        mem_addr_r  <= mem_addr_r;
        mem_wdata_r <= mem_wdata_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign cpu_run   = cpu_run_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
Boot-time program loader that sits directly upstream of the 16x8 RAM and the micro-computer core. It accepts a framed byte stream over a valid/ready handshake and writes the payload into RAM. It then validates a checksum and releases the CPU to run. Until a load completes cleanly, the core is held (cpu_run=0) and the loader owns the RAM write port.

Parameters:
DATA_W, 8, word width (matches RAM/AC/DR width)
ADDR_W, 4, RAM address width
DEPTH, 16, number of RAM words (2**ADDR_W)
BASE_ADDR, 0, first RAM address written by a load

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a (re)load; sampled in IDLE, RUN, ERROR only
in_valid  input  1  upstream byte valid
in_data  input  DATA_W  upstream byte
in_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  RAM write strobe (drives RAM write, muxed ahead of the CPU's write)
mem_addr  output  ADDR_W  RAM write address
mem_wdata  output  DATA_W  RAM write data
cpu_run  output  1  1 = core may run; 0 = core held
done  output  1  level: last load succeeded
err  output  1  level: last load failed (bad length or checksum)
words_loaded  output  ADDR_W+1  payload bytes written in current/last load

Behaviour:
- Frame format: LEN byte (N, valid range 1..DEPTH), then N payload bytes, then CSUM byte = sum of payload mod 2**DATA_W.
- Accept means in_valid & in_ready in the same cycle. in_ready is a Moore output: 1 in LEN, DATA and CSUM; 0 elsewhere.
- Reset: state IDLE; in_ready, mem_we, cpu_run, done and err are 0; mem_addr=0, mem_wdata=0, words_loaded=0. Internal sum and remaining count are 0.
- IDLE: start=1 -> LEN next cycle.
- LEN, on accept:
  - N==0 or N>DEPTH -> ERROR.
  - Otherwise: remaining=N, wr_addr=BASE_ADDR, sum=0, words_loaded=0, done=0, err=0 -> DATA.
- DATA, on accept:
  - Next cycle: mem_we=1 for exactly one cycle, with mem_addr=wr_addr and mem_wdata=in_data (write latency 1).
  - sum += byte mod 256; wr_addr += 1, wrapping mod DEPTH (BASE_ADDR+N may wrap to 0); words_loaded += 1.
  - Last byte (remaining==1) -> CSUM.
- CSUM, on accept:
  - byte==sum -> RUN; cpu_run=1 and done=1 from the next cycle.
  - Mismatch -> ERROR. Already-written RAM words are left as written.
- RUN: cpu_run held 1. start=1 -> LEN; cpu_run and done drop to 0 the next cycle.
- ERROR: err=1, cpu_run=0. start=1 -> LEN, which clears err.
- No accept (in_valid=0): state, sum, address and count hold. No timeout.
- start is ignored in LEN, DATA and CSUM.
- mem_we is never asserted outside the cycle after a DATA accept. mem_addr and mem_wdata hold their last values otherwise.
- Reset mid-load returns everything to reset values next cycle. The partial RAM contents are not cleared.
- cpu_run and mem_we are never 1 in the same cycle.

Decomposition:
- Shared header/package: state encodings (IDLE, LEN, DATA, CSUM, RUN, ERROR as 3-bit localparams), DATA_W/ADDR_W/DEPTH defaults, and MAX_LEN=DEPTH.
- One sub-module, ram_loader_acc: mod-256 checksum accumulator plus wrapping address/count register, with clear/enable inputs.
- The FSM and handshake stay in ram_loader.

Test Plan:
- Nominal: reset, start, stream 03,0A,0B,0C,21 -> three mem_we pulses, at addr 0/1/2 with data 0A/0B/0C, each one cycle after its accept. Then cpu_run=1, done=1, words_loaded=3.
- Bad checksum: 02,F0,20,00 -> writes at addr 0/1 occur, then err=1, cpu_run=0, done=0. A following start plus a valid frame recovers to done=1, err=0.
- Length bounds:
  - LEN=00 -> ERROR with no mem_we.
  - LEN=11 (17) -> ERROR.
  - LEN=10 (16) with 16 bytes of 01 and CSUM=10 -> addr 0..F written, done=1, words_loaded=16.
- Backpressure gaps: insert 0-3 idle cycles (in_valid=0) between bytes of the nominal frame -> identical writes/result; no mem_we on idle cycles.
- Wrap with BASE_ADDR=E: 03,01,02,03,06 -> writes at addr E, F, 0.
- Reload/reset: start in RUN -> cpu_run drops next cycle. Reset asserted mid-DATA -> all outputs at reset values next cycle, and start is ignored during DATA.
